// File: rtl/vga_frame_checker.sv
// Frame checker for the VGA pixel stream. It compares in-window pixels against
// an expected RGB stream, counts channel mismatches, latches the first failing
// pixel, builds a CRC-32 frame signature and aborts past a mismatch threshold.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | not armed, status holds
// S_WAIT_LOW  | armed, waiting for vsync to go low
// S_WAIT_HIGH | waiting for vsync to return high (start of a frame)
// S_ACTIVE    | checking pixels until the next vsync falling edge
// S_DONE      | one-cycle frame-complete strobe
// S_ABORT     | threshold exceeded, holds until the next Start
module vga_frame_checker #(
  parameter int COLOR_W        = 10,
  parameter int EXP_W          = 8,
  parameter int VIEW_LEFT      = 160,
  parameter int VIEW_RIGHT     = 480,
  parameter int VIEW_TOP       = 120,
  parameter int VIEW_BOTTOM    = 360,
  parameter int MAX_MISMATCHES = 10,
  parameter int CNT_W          = 17
) (
  input  logic                 Clock_50_i,
  input  logic                 Resetn_i,
  input  logic                 Start_i,
  input  logic [1:0]           Mode_i,
  input  logic                 VGA_vsync_n_i,
  input  logic                 Pixel_en_i,
  input  logic [9:0]           Pixel_X_i,
  input  logic [9:0]           Pixel_Y_i,
  input  logic [COLOR_W-1:0]   Pixel_R_i,
  input  logic [COLOR_W-1:0]   Pixel_G_i,
  input  logic [COLOR_W-1:0]   Pixel_B_i,
  input  logic                 Exp_valid_i,
  input  logic [3*EXP_W-1:0]   Exp_data_i,
  output logic                 Exp_ready_o,
  output logic                 Busy_o,
  output logic                 Frame_done_o,
  output logic                 Abort_o,
  output logic                 Underflow_o,
  output logic [CNT_W-1:0]     Mismatch_count_o,
  output logic [CNT_W-1:0]     Pixel_count_o,
  output logic [9:0]           First_mm_x_o,
  output logic [9:0]           First_mm_y_o,
  output logic [1:0]           First_mm_ch_o,
  output logic [31:0]          Signature_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOW, S_WAIT_HIGH, S_ACTIVE, S_DONE, S_ABORT
  } state_t;

  localparam logic [9:0]       X_LO     = 10'(VIEW_LEFT);
  localparam logic [9:0]       X_HI     = 10'(VIEW_RIGHT);
  localparam logic [9:0]       Y_LO     = 10'(VIEW_TOP);
  localparam logic [9:0]       Y_HI     = 10'(VIEW_BOTTOM);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MM_LIMIT = CNT_W'(MAX_MISMATCHES);
  localparam int               PAD_W    = COLOR_W - EXP_W;

  state_t             state_q, state_d;
  logic               vsync_q;
  logic               abort_q, abort_d;
  logic               underflow_q, underflow_d;
  logic [CNT_W-1:0]   mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [9:0]         fx_q, fx_d, fy_q, fy_d;
  logic [1:0]         fch_q, fch_d;
  logic [31:0]        sig_q, sig_d;

  logic               cmp_en, sig_en, in_win;
  logic [COLOR_W-1:0] exp_r, exp_g, exp_b;
  logic [2:0]         neq;
  logic [1:0]         n_neq;
  logic [CNT_W:0]     mm_sum;

  // MSB-first CRC-32 (poly 04C11DB7, no reflection) over 24 bits in one step
  function automatic logic [31:0] crc24(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  // Mode 3 behaves like mode 2: both compare and sign
  assign cmp_en = (Mode_i != 2'd1);
  assign sig_en = (Mode_i != 2'd0);
  assign in_win = (state_q == S_ACTIVE) && Pixel_en_i &&
                  (Pixel_X_i >= X_LO) && (Pixel_X_i < X_HI) &&
                  (Pixel_Y_i >= Y_LO) && (Pixel_Y_i < Y_HI);

  // Expected channels are left-aligned into the DUT colour width, zero-filled
  assign exp_r  = COLOR_W'(Exp_data_i[3*EXP_W-1 -: EXP_W]) << PAD_W;
  assign exp_g  = COLOR_W'(Exp_data_i[2*EXP_W-1 -: EXP_W]) << PAD_W;
  assign exp_b  = COLOR_W'(Exp_data_i[EXP_W-1   -: EXP_W]) << PAD_W;
  assign neq    = {Pixel_B_i != exp_b, Pixel_G_i != exp_g, Pixel_R_i != exp_r};
  assign n_neq  = 2'(neq[0]) + 2'(neq[1]) + 2'(neq[2]);
  assign mm_sum = {1'b0, mm_cnt_q} + (CNT_W+1)'(n_neq);

  assign Exp_ready_o      = in_win && Exp_valid_i && cmp_en;
  assign Busy_o           = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH) ||
                            (state_q == S_ACTIVE);
  assign Frame_done_o     = (state_q == S_DONE);
  assign Abort_o          = abort_q;
  assign Underflow_o      = underflow_q;
  assign Mismatch_count_o = mm_cnt_q;
  assign Pixel_count_o    = pix_cnt_q;
  assign First_mm_x_o     = fx_q;
  assign First_mm_y_o     = fy_q;
  assign First_mm_ch_o    = fch_q;
  assign Signature_o      = sig_q;

  // Next-state and status update; Start overrides every other event
  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    underflow_d = underflow_q;
    mm_cnt_d    = mm_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    fx_d        = fx_q;
    fy_d        = fy_q;
    fch_d       = fch_q;
    sig_d       = sig_q;
    if (Start_i) begin
      state_d     = S_WAIT_LOW;
      abort_d     = 1'b0;
      underflow_d = 1'b0;
      mm_cnt_d    = '0;
      pix_cnt_d   = '0;
      fx_d        = '0;
      fy_d        = '0;
      fch_d       = '0;
      sig_d       = 32'hFFFF_FFFF;
    end else begin
      case (state_q)
        S_IDLE:      ;
        S_WAIT_LOW:  if (!VGA_vsync_n_i) state_d = S_WAIT_HIGH;
        S_WAIT_HIGH: if (VGA_vsync_n_i) state_d = S_ACTIVE;
        S_ACTIVE: begin
          if (vsync_q && !VGA_vsync_n_i) state_d = S_DONE;
          if (in_win) begin
            pix_cnt_d = (pix_cnt_q == CNT_MAX) ? pix_cnt_q : pix_cnt_q + CNT_W'(1);
            if (cmp_en) begin
              if (!Exp_valid_i) begin
                underflow_d = 1'b1;
              end else begin
                mm_cnt_d = mm_sum[CNT_W] ? CNT_MAX : mm_sum[CNT_W-1:0];
                if ((mm_cnt_q == '0) && (neq != 3'b000)) begin
                  fx_d  = Pixel_X_i;
                  fy_d  = Pixel_Y_i;
                  fch_d = neq[0] ? 2'd0 : (neq[1] ? 2'd1 : 2'd2);
                end
                if (mm_cnt_d > MM_LIMIT) begin
                  abort_d = 1'b1;
                  state_d = S_ABORT;
                end
              end
            end
            if (sig_en)
              sig_d = crc24(sig_q, {Pixel_R_i[COLOR_W-1 -: 8], Pixel_G_i[COLOR_W-1 -: 8],
                                    Pixel_B_i[COLOR_W-1 -: 8]});
          end
        end
        S_DONE:      state_d = S_IDLE;
        S_ABORT:     ;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // State register and previous-vsync sample for edge detection
  always_ff @(posedge Clock_50_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b1;
    end else begin
      state_q <= state_d;
      vsync_q <= VGA_vsync_n_i;
    end
  end

  // Status registers
  always_ff @(posedge Clock_50_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      abort_q     <= 1'b0;
      underflow_q <= 1'b0;
      mm_cnt_q    <= '0;
      pix_cnt_q   <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      fch_q       <= '0;
      sig_q       <= 32'hFFFF_FFFF;
    end else begin
      abort_q     <= abort_d;
      underflow_q <= underflow_d;
      mm_cnt_q    <= mm_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      fch_q       <= fch_d;
      sig_q       <= sig_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker on a shrunken raster (12x7 frame, 8x4 window)
// so complete frames stay short.
module tb_vga_frame_checker;

  localparam int CW = 10;
  localparam int EW = 8;
  localparam int CN = 17;

  logic          clk = 1'b0;
  logic          Resetn, Start, VGA_vsync_n, Pixel_en, Exp_valid;
  logic [1:0]    Mode;
  logic [9:0]    Pixel_X, Pixel_Y;
  logic [CW-1:0] Pixel_R, Pixel_G, Pixel_B;
  logic [3*EW-1:0] Exp_data;
  logic          Exp_ready, Busy, Frame_done, Abort, Underflow;
  logic [CN-1:0] Mismatch_count, Pixel_count;
  logic [9:0]    First_mm_x, First_mm_y;
  logic [1:0]    First_mm_ch;
  logic [31:0]   Signature;

  int checks = 0;
  int failures = 0;
  int rdy_cnt = 0;
  int fd_cnt = 0;
  int bad_mode = 0;
  int uf_x = -1;
  int uf_y = -1;
  logic [31:0] model_sig;
  logic        model_live;
  logic [31:0] sig_a, sig_b;

  vga_frame_checker #(
    .COLOR_W(CW), .EXP_W(EW), .VIEW_LEFT(2), .VIEW_RIGHT(10), .VIEW_TOP(1),
    .VIEW_BOTTOM(5), .MAX_MISMATCHES(10), .CNT_W(CN)
  ) dut (
    .Clock_50_i(clk), .Resetn_i(Resetn), .Start_i(Start), .Mode_i(Mode),
    .VGA_vsync_n_i(VGA_vsync_n), .Pixel_en_i(Pixel_en), .Pixel_X_i(Pixel_X),
    .Pixel_Y_i(Pixel_Y), .Pixel_R_i(Pixel_R), .Pixel_G_i(Pixel_G), .Pixel_B_i(Pixel_B),
    .Exp_valid_i(Exp_valid), .Exp_data_i(Exp_data), .Exp_ready_o(Exp_ready),
    .Busy_o(Busy), .Frame_done_o(Frame_done), .Abort_o(Abort), .Underflow_o(Underflow),
    .Mismatch_count_o(Mismatch_count), .Pixel_count_o(Pixel_count),
    .First_mm_x_o(First_mm_x), .First_mm_y_o(First_mm_y), .First_mm_ch_o(First_mm_ch),
    .Signature_o(Signature)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Exp_ready) rdy_cnt++;
    if (Frame_done) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Shift-register form: XOR data into the top, then 24 polynomial divisions
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 24; i++)
      r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  function automatic logic [29:0] clean_color(input int x, input int y);
    logic [7:0] r8, g8, b8;
    r8 = 8'(x * 7 + y * 3);
    g8 = 8'((x * 5) ^ (y * 11));
    b8 = 8'(x + y * 17 + 9);
    return {r8, 2'b00, g8, 2'b00, b8, 2'b00};
  endfunction

  function automatic logic [29:0] dut_color(input int x, input int y);
    logic [29:0] c;
    c = clean_color(x, y);
    if (bad_mode == 1 && x == 5 && y == 2) c[29:20] = 10'h3FC;
    if (bad_mode == 2 && ((y == 1 && x >= 2 && x <= 9) || (y == 2 && x >= 2 && x <= 4)))
      c[19:10] = c[19:10] ^ 10'h004;
    if (bad_mode == 3 && x == 6 && y == 3) c[19:10] = c[19:10] ^ 10'h010;
    return c;
  endfunction

  function automatic logic [23:0] exp_word(input int x, input int y);
    logic [29:0] c;
    logic [23:0] w;
    c = clean_color(x, y);
    w = {c[29:22], c[19:12], c[9:2]};
    if (bad_mode == 1 && x == 5 && y == 2) w[23:16] = 8'h10;
    return w;
  endfunction

  // One full frame; rst_row >= 0 pulses Resetn low at the start of that row
  task automatic run_frame(input logic [1:0] mode, input int rst_row);
    logic [29:0] c;
    rdy_cnt = 0; fd_cnt = 0; model_sig = 32'hFFFF_FFFF; model_live = 1'b1;
    Mode = mode;
    Start = 1'b1; tick(); Start = 1'b0;
    VGA_vsync_n = 1'b0; tick(); tick();
    VGA_vsync_n = 1'b1; tick();
    for (int y = 0; y < 7; y++) begin
      for (int x = 0; x < 12; x++) begin
        if (y == rst_row && x == 0) begin
          #1 Resetn = 1'b0;
          #1;
          chk("rst_mid_sig", Signature, 32'hFFFF_FFFF);
          chk("rst_mid_pix", 32'(Pixel_count), 0);
          chk("rst_mid_busy", 32'(Busy), 0);
          chk("rst_mid_mm", 32'(Mismatch_count), 0);
          Resetn = 1'b1;
          model_live = 1'b0;
        end
        c = dut_color(x, y);
        Pixel_X = 10'(x); Pixel_Y = 10'(y);
        Pixel_R = c[29:20]; Pixel_G = c[19:10]; Pixel_B = c[9:0];
        Exp_data = exp_word(x, y);
        Exp_valid = !(x == uf_x && y == uf_y);
        Pixel_en = 1'b1;
        if (model_live && mode != 2'd0 && x >= 2 && x < 10 && y >= 1 && y < 5)
          model_sig = crc_model(model_sig, {c[29:22], c[19:12], c[9:2]});
        tick();
        Pixel_en = 1'b0;
        tick();
      end
    end
    VGA_vsync_n = 1'b0; tick(); tick();
    VGA_vsync_n = 1'b1; tick();
  endtask

  typedef struct {
    logic       en;
    int         x;
    int         y;
    logic [9:0] r, g, b;
    logic       ev;
    logic [23:0] ed;
    logic       rdy;
    int         mm;
    int         pix;
    logic       uf;
  } vec_t;

  vec_t tv[12];

  initial begin
    // en x  y  R       G       B       ev  exp data     rdy mm pix uf
    tv[0]  = '{1'b1, 2, 1, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'h408030, 1'b1, 0, 1, 1'b0};
    tv[1]  = '{1'b1, 9, 4, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'h408030, 1'b1, 0, 2, 1'b0};
    tv[2]  = '{1'b1, 10, 3, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'hFFFFFF, 1'b0, 0, 2, 1'b0};
    tv[3]  = '{1'b1, 1, 3, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'hFFFFFF, 1'b0, 0, 2, 1'b0};
    tv[4]  = '{1'b1, 5, 5, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'hFFFFFF, 1'b0, 0, 2, 1'b0};
    tv[5]  = '{1'b1, 5, 0, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'hFFFFFF, 1'b0, 0, 2, 1'b0};
    tv[6]  = '{1'b0, 5, 2, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'hFFFFFF, 1'b0, 0, 2, 1'b0};
    tv[7]  = '{1'b1, 5, 2, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'h408131, 1'b1, 2, 3, 1'b0};
    tv[8]  = '{1'b1, 6, 2, 10'h101, 10'h200, 10'h0C0, 1'b1, 24'h408030, 1'b1, 3, 4, 1'b0};
    tv[9]  = '{1'b1, 7, 2, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'h418131, 1'b1, 6, 5, 1'b0};
    tv[10] = '{1'b1, 8, 2, 10'h100, 10'h200, 10'h0C0, 1'b0, 24'h000000, 1'b0, 6, 6, 1'b1};
    tv[11] = '{1'b1, 3, 3, 10'h100, 10'h200, 10'h0C0, 1'b1, 24'h7F8030, 1'b1, 7, 7, 1'b1};

    Resetn = 1'b0; Start = 1'b0; Mode = 2'd2; VGA_vsync_n = 1'b1; Pixel_en = 1'b1;
    Pixel_X = 10'd3; Pixel_Y = 10'd2; Pixel_R = '0; Pixel_G = '0; Pixel_B = '0;
    Exp_valid = 1'b1; Exp_data = '0;
    #23;
    chk("reset_sig", Signature, 32'hFFFF_FFFF);
    chk("reset_mm", 32'(Mismatch_count), 0);
    chk("reset_pix", 32'(Pixel_count), 0);
    chk("reset_flags", {27'd0, Busy, Frame_done, Abort, Underflow, Exp_ready}, 0);
    chk("reset_first", {12'd0, First_mm_x, First_mm_y, First_mm_ch}, 0);
    Resetn = 1'b1; Pixel_en = 1'b0;
    tick();

    // Single-pixel vectors in compare-only mode
    Mode = 2'd0;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("armed_busy", 32'(Busy), 1);
    VGA_vsync_n = 1'b0; tick();
    VGA_vsync_n = 1'b1; tick();
    for (int i = 0; i < 12; i++) begin
      Pixel_en = tv[i].en; Pixel_X = 10'(tv[i].x); Pixel_Y = 10'(tv[i].y);
      Pixel_R = tv[i].r; Pixel_G = tv[i].g; Pixel_B = tv[i].b;
      Exp_valid = tv[i].ev; Exp_data = tv[i].ed;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(Exp_ready), 32'(tv[i].rdy));
      tick();
      chk($sformatf("vec%0d_mm", i), 32'(Mismatch_count), 32'(tv[i].mm));
      chk($sformatf("vec%0d_pix", i), 32'(Pixel_count), 32'(tv[i].pix));
      chk($sformatf("vec%0d_uf", i), 32'(Underflow), 32'(tv[i].uf));
    end
    Pixel_en = 1'b0;
    chk("vec_first_x", 32'(First_mm_x), 5);
    chk("vec_first_y", 32'(First_mm_y), 2);
    chk("vec_first_ch", 32'(First_mm_ch), 1);
    chk("vec_sig_mode0", Signature, 32'hFFFF_FFFF);
    VGA_vsync_n = 1'b0; tick();
    chk("vec_done_pulse", {30'd0, Frame_done, Busy}, 32'h2);
    tick();
    chk("vec_done_clear", {30'd0, Frame_done, Busy}, 0);
    VGA_vsync_n = 1'b1; tick();

    // Clean frame, compare + signature
    bad_mode = 0;
    run_frame(2'd2, -1);
    chk("clean_pix", 32'(Pixel_count), 32);
    chk("clean_ready", 32'(rdy_cnt), 32);
    chk("clean_mm", 32'(Mismatch_count), 0);
    chk("clean_done", 32'(fd_cnt), 1);
    chk("clean_flags", {30'd0, Abort, Underflow}, 0);
    chk("clean_sig", Signature, model_sig);

    // One red mismatch, mode 3 acts as compare + signature
    bad_mode = 1;
    run_frame(2'd3, -1);
    chk("red_mm", 32'(Mismatch_count), 1);
    chk("red_first", {12'd0, First_mm_x, First_mm_y, First_mm_ch}, {12'd0, 10'd5, 10'd2, 2'd0});
    chk("red_sig", Signature, model_sig);
    chk("red_done", 32'(fd_cnt), 1);

    // Eleven green mismatches abort on the eleventh
    bad_mode = 2;
    run_frame(2'd2, -1);
    chk("abort_flag", 32'(Abort), 1);
    chk("abort_mm", 32'(Mismatch_count), 11);
    chk("abort_ready", 32'(rdy_cnt), 11);
    chk("abort_no_done", 32'(fd_cnt), 0);
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_first", {12'd0, First_mm_x, First_mm_y, First_mm_ch}, {12'd0, 10'd2, 10'd1, 2'd1});
    Start = 1'b1; tick(); Start = 1'b0;
    chk("rearm_counts", {Mismatch_count, Pixel_count[14:0]}, 0);
    chk("rearm_flags", {29'd0, Abort, Underflow, Busy}, 1);
    chk("rearm_sig", Signature, 32'hFFFF_FFFF);

    // Missing expected word at the window corner
    bad_mode = 0; uf_x = 2; uf_y = 1;
    run_frame(2'd2, -1);
    chk("uf_flag", 32'(Underflow), 1);
    chk("uf_mm", 32'(Mismatch_count), 0);
    chk("uf_pix", 32'(Pixel_count), 32);
    chk("uf_ready", 32'(rdy_cnt), 31);
    uf_x = -1; uf_y = -1;

    // Signature only: repeatable, no Exp_ready, sensitive to one bit
    run_frame(2'd1, -1);
    sig_a = Signature;
    chk("sig1_model", sig_a, model_sig);
    chk("sig1_ready", 32'(rdy_cnt), 0);
    run_frame(2'd1, -1);
    sig_b = Signature;
    chk("sig2_same", sig_b, sig_a);
    chk("sig2_ready", 32'(rdy_cnt), 0);
    bad_mode = 3;
    run_frame(2'd1, -1);
    chk("sig3_model", Signature, model_sig);
    chk("sig3_differs", 32'(Signature != sig_a), 1);

    // Reset mid-frame, then a normal frame
    bad_mode = 0;
    run_frame(2'd2, 3);
    chk("rst_no_done", 32'(fd_cnt), 0);
    chk("rst_idle", {30'd0, Busy, Abort}, 0);
    chk("rst_pix_after", 32'(Pixel_count), 0);
    run_frame(2'd2, -1);
    chk("post_rst_pix", 32'(Pixel_count), 32);
    chk("post_rst_done", 32'(fd_cnt), 1);
    chk("post_rst_sig", Signature, model_sig);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_frame_checker.md
Name: vga_frame_checker

Overview:
- Synthesizable, parametrised successor to the VGA self-check in our decoder bench.
- Monitors the VGA pixel stream from the display unit during one frame and compares each in-window pixel against an expected RGB stream supplied through a valid/ready port.
- Counts channel mismatches, latches the first failure, computes a CRC-32 frame signature and aborts past a threshold.
- Sits beside the VGA unit in the project top; usable on-board (LEDs/7-seg) and in simulation.

Parameters:
- COLOR_W, 10, width of each DUT colour channel.
- EXP_W, 8, width of each expected channel; left-aligned into COLOR_W, zero-filled.
- VIEW_LEFT, 160, first checked column (inclusive).
- VIEW_RIGHT, 480, last checked column (exclusive).
- VIEW_TOP, 120, first checked row (inclusive).
- VIEW_BOTTOM, 360, last checked row (exclusive).
- MAX_MISMATCHES, 10, abort once the count exceeds this value.
- CNT_W, 17, width of the mismatch and pixel counters.

Ports:
- Clock_50 in 1 system clock.
- Resetn in 1 asynchronous active-low reset.
- Start in 1 one-cycle pulse; clears status and arms the checker.
- Mode in 2: 0=compare, 1=signature only, 2=compare+signature, 3=reserved (treated as 2).
- VGA_vsync_n in 1 vertical sync from the VGA controller, active low.
- Pixel_en in 1 pixel strobe, every other clock in 640x480.
- Pixel_X in 10 current column.
- Pixel_Y in 10 current row.
- Pixel_R, Pixel_G, Pixel_B in COLOR_W each: DUT colour.
- Exp_valid in 1 expected word available.
- Exp_data in 3*EXP_W expected {R,G,B}, R in the MSBs.
- Exp_ready out 1 expected word consumed this cycle.
- Busy out 1 armed or checking.
- Frame_done out 1 one-cycle pulse at the end of a frame.
- Abort out 1 sticky; threshold exceeded.
- Underflow out 1 sticky; expected data missing when needed.
- Mismatch_count out CNT_W saturating channel-mismatch total.
- Pixel_count out CNT_W in-window pixels seen.
- First_mm_x out 10 column of the first mismatch.
- First_mm_y out 10 row of the first mismatch.
- First_mm_ch out 2 channel of the first mismatch: 0=R, 1=G, 2=B.
- Signature out 32 CRC-32 of the frame.

Behaviour:
- Reset (async, Resetn=0):
  - State enters S_IDLE.
  - All outputs are 0, except Signature=32'hFFFFFFFF.
  - The previous-vsync register resets to 1.
- States:
  - S_IDLE: Start -> S_WAIT_LOW.
  - S_WAIT_LOW: VGA_vsync_n=0 -> S_WAIT_HIGH.
  - S_WAIT_HIGH: VGA_vsync_n=1 -> S_ACTIVE.
  - S_ACTIVE: falling edge of vsync (previous registered value 1, current 0) -> S_DONE. Abort condition -> S_ABORT.
  - S_DONE: Frame_done=1 for one cycle, then -> S_IDLE.
  - S_ABORT: holds until Start; no Frame_done is issued.
- Start in any state clears all status (Mismatch_count, Pixel_count, first-mismatch fields, Abort, Underflow; Signature reloads FFFFFFFF) and goes to S_WAIT_LOW. Start has priority over all other events.
- Busy=1 in S_WAIT_LOW, S_WAIT_HIGH and S_ACTIVE.
- A pixel is in-window when state=S_ACTIVE, Pixel_en=1, VIEW_LEFT<=Pixel_X<VIEW_RIGHT and VIEW_TOP<=Pixel_Y<VIEW_BOTTOM.
- For each in-window pixel:
  - Pixel_count increments, saturating at all-ones.
  - Exp_ready is combinational: Exp_ready = in-window & Exp_valid & Mode!=1.
  - If Mode!=1 and Exp_valid=0: Underflow is set, no compare is made, and the pixel is still counted and signed.
  - Compare: channel expected = {Exp_ch, (COLOR_W-EXP_W) zeros}. Mismatch_count increases by the number of unequal channels (0..3) in a single cycle, saturating.
  - First mismatch: latched only while Mismatch_count==0. The lowest unequal channel index wins.
  - If the new Mismatch_count > MAX_MISMATCHES: Abort=1 and next state is S_ABORT; Exp_ready is 0 afterwards.
  - Signature (Mode!=0): CRC-32, poly 04C11DB7, MSB-first, no reflection, no final XOR. Consumes 24 bits per pixel in one cycle: {R[COLOR_W-1 -: 8], G[...], B[...]}.
- Latency: all status updates are registered one cycle after the in-window strobe.
- Out-of-window pixels, and pixels in any state other than S_ACTIVE, are ignored; Exp_ready=0.
- Status values hold after S_DONE/S_ABORT until the next Start or reset.
- Resetn low mid-frame: immediate return to reset values; no Frame_done.

Test Plan:
1. Defaults, 640x480 timing, expected stream = DUT pixels, Mode=2 -> Pixel_count=76800, Exp_ready pulses=76800, Mismatch_count=0, exactly one Frame_done at vsync fall, Abort=0, Underflow=0.
2. Same stimulus, but expected R=8'h10 while DUT R=10'h3FC at (200,130) -> Mismatch_count=1, First_mm_x=200, First_mm_y=130, First_mm_ch=0.
3. Eleven single-channel mismatches across the first rows -> Abort=1 on the 11th, Mismatch_count=11, no further Exp_ready, no Frame_done; Start re-arms with all counters 0.
4. Exp_valid=0 for in-window pixel (160,120) -> Underflow=1, Mismatch_count=0, Pixel_count still 76800 at frame end.
5. Mode=1 with a constant frame, run twice -> identical Signature both frames matching the golden model, Exp_ready never asserted. Flipping one G bit in one pixel changes Signature.
6. Resetn pulsed low at row 200 -> all outputs reset (Signature=FFFFFFFF) asynchronously, state S_IDLE, no Frame_done; a later Start works normally.
